// File: rtl/mrv32_lsu.sv
// mrv32_lsu: multi-cycle load/store unit between execute and a valid/ready data-memory port.
// Optional misaligned-access trap is compiled in with MRV32_LSU_MISALIGN_TRAP_EN.
module mrv32_lsu #(
  parameter int XLEN           = 32,
  parameter int ADDR_WIDTH     = 20,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [XLEN-1:0]       req_addr,
  input  logic [XLEN-1:0]       req_wdata,
  input  logic [4:0]            req_rd,
  output logic                  rsp_valid,
  output logic [XLEN-1:0]       rsp_rdata,
  output logic [4:0]            rsp_rd,
  output logic                  rsp_err,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [XLEN-1:0]       mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_rvalid,
  input  logic [XLEN-1:0]       mem_rdata,
  output logic                  busy
);
  // state | meaning
  // IDLE  | accepting a new access from execute
  // REQ   | mem_valid held with stable mem_* until mem_ready
  // WAIT  | load accepted by the bus, waiting for mem_rvalid
  // RESP  | one-cycle rsp_valid pulse back to writeback
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  if (XLEN != 32) begin : g_bad_xlen
    $error("mrv32_lsu supports XLEN=32 only");
  end

  localparam int CW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int TC_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CW-1:0] TC_LAST = CW'(TC_LAST_I);
  localparam logic [CW-1:0] TC_MAX  = CW'(TIMEOUT_CYCLES);

  state_t        state, state_nx;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [CW-1:0] tmr_cnt;
  logic          timeout;
  logic          f3_legal;
  logic          misalign;
  logic          err_nx;
  logic          take_load;
  logic [31:0]   st_wdata;
  logic [3:0]    st_wstrb;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;
  logic          unused_addr_hi;

  assign unused_addr_hi = ^req_addr[XLEN-1:ADDR_WIDTH];
  assign busy    = (state != IDLE);
  assign timeout = (TIMEOUT_CYCLES != 0) && (tmr_cnt >= TC_LAST);

  always_comb begin
    if (req_we)
      f3_legal = (req_funct3 == 3'b000) || (req_funct3 == 3'b001) || (req_funct3 == 3'b010);
    else
      f3_legal = (req_funct3 != 3'b011) && (req_funct3 != 3'b110) && (req_funct3 != 3'b111);
  end

`ifdef MRV32_LSU_MISALIGN_TRAP_EN
  always_comb begin
    misalign = 1'b0;
    if (req_funct3[1:0] == 2'b01)
      misalign = req_addr[0];
    else if (req_funct3[1:0] == 2'b10)
      misalign = |req_addr[1:0];
  end
`else
  // Misaligned halves/words fall back to the lane picked by the low address bits.
  assign misalign = 1'b0;
`endif

  always_comb begin
    st_wdata = '0;
    st_wstrb = '0;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00: begin
          st_wdata = {4{req_wdata[7:0]}};
          st_wstrb = 4'b0001 << req_addr[1:0];
        end
        2'b01: begin
          st_wdata = {2{req_wdata[15:0]}};
          st_wstrb = 4'b0011 << {req_addr[1], 1'b0};
        end
        default: begin
          st_wdata = req_wdata;
          st_wstrb = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    case (off_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    err_nx    = 1'b0;
    take_load = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (!f3_legal || misalign) begin
            state_nx = RESP;
            err_nx   = 1'b1;
          end else begin
            state_nx = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          state_nx = mem_we ? RESP : WAIT;
        end else if (timeout) begin
          state_nx = RESP;
          err_nx   = 1'b1;
        end
      end
      WAIT: begin
        if (mem_rvalid) begin
          state_nx  = RESP;
          take_load = 1'b1;
        end else if (timeout) begin
          state_nx = RESP;
          err_nx   = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Saturates so a late handshake after the terminal count cannot wrap the timer.
  always_ff @(posedge clk) begin
    if (rst)
      tmr_cnt <= '0;
    else if (state == IDLE)
      tmr_cnt <= '0;
    else if (((state == REQ) || (state == WAIT)) && (tmr_cnt != TC_MAX))
      tmr_cnt <= tmr_cnt + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q      <= '0;
      off_q     <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      rsp_rd    <= '0;
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      if ((state == IDLE) && req_valid) begin
        f3_q   <= req_funct3;
        off_q  <= req_addr[1:0];
        rsp_rd <= req_rd;
        if (state_nx == REQ) begin
          mem_valid <= 1'b1;
          mem_we    <= req_we;
          mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_wdata <= st_wdata;
          mem_wstrb <= st_wstrb;
        end
      end
      if ((state == REQ) && (state_nx != REQ))
        mem_valid <= 1'b0;
      if (state_nx == RESP) begin
        rsp_valid <= 1'b1;
        rsp_err   <= err_nx;
        rsp_rdata <= take_load ? ld_ext : '0;
      end
    end
  end

endmodule
